kim_sync_fifo: RTL and testbench

- Single-clock FIFO with valid/ready on both sides.
- Sits directly upstream of the skid buffer stage in the FIFO-with-skid-buffer path; its m_* port drives the skid buffer's s_* port.
- Storage is a register array plus one registered output word (first-word-fall-through), so m_data/m_valid come straight from flops.
- Exposes occupancy and almost-full status for upstream flow control.

---
 rtl/kim_sync_fifo.sv | 104 ++++++++++
 tb/tb_kim_sync_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/kim_sync_fifo.sv
// Single-clock valid/ready FIFO: register array plus a registered output word
// (first-word-fall-through, no bypass), with registered occupancy and almost-full.
module kim_sync_fifo #(
  parameter int DATA_WIDTH         = 8,
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_TH    = PW'(ALMOST_FULL_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  almost_full_q, almost_full_d;
  logic                  ready_en_q;

  logic [PW-1:0] mem_cnt, mem_cnt_nxt;
  logic          empty, full;
  logic          wr_en, load, rd_hs;

  // s_ready comes only from flops so it never combinationally depends on s_valid/m_ready.
  always_comb begin
    mem_cnt = wr_ptr_q - rd_ptr_q;
    empty   = (mem_cnt == '0);
    full    = (mem_cnt == FULL_CNT);
    s_ready = ready_en_q & ~full;
    wr_en   = s_valid & s_ready;
    rd_hs   = m_valid_q & m_ready;
    load    = ~empty & (~m_valid_q | m_ready);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(load);

    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    if (load) begin
      m_valid_d = 1'b1;
      m_data_d  = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    end else if (rd_hs) begin
      m_valid_d = 1'b0;
    end

    count_d = count_q;
    if (wr_en && !rd_hs)
      count_d = count_q + PW'(1);
    else if (!wr_en && rd_hs)
      count_d = count_q - PW'(1);

    mem_cnt_nxt   = wr_ptr_d - rd_ptr_d;
    almost_full_d = (mem_cnt_nxt >= AF_TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      ready_en_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      ready_en_q    <= 1'b1;
    end
  end

  // Storage is deliberately left unreset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= s_data;
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign count       = count_q;
  assign almost_full = almost_full_q;

endmodule

// File: tb/tb_kim_sync_fifo.sv
// Directed bench for kim_sync_fifo: vector tables for reset/handshake timing,
// hand-written fill/drain/stream/random/reset sequences.
module tb_kim_sync_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid, s_ready, m_valid, m_ready, almost_full;
  logic [7:0] s_data, m_data;
  logic [4:0] count;

  int cmp   = 0;
  int fails = 0;

  typedef struct packed {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    logic       rdy;
    logic       mv;
    logic [7:0] md;
    logic [4:0] cnt;
    logic       af;
  } vec_t;

  vec_t tbl [10];
  vec_t rtbl[6];

  logic [7:0] q[$];
  logic [7:0] nxt;
  logic [7:0] hold_d;
  logic [7:0] exp_w;
  logic       hold;

  kim_sync_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ALMOST_FULL_THRESH(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " s_ready"}, 32'(s_ready), 32'(v.rdy));
    check({tag, " m_valid"}, 32'(m_valid), 32'(v.mv));
    check({tag, " m_data"}, 32'(m_data), 32'(v.md));
    check({tag, " count"}, 32'(count), 32'(v.cnt));
    check({tag, " almost_full"}, 32'(almost_full), 32'(v.af));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //           sv  sd     mr   rdy  mv   md     cnt   af
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0};
    tbl[4] = '{1'b1, 8'hB1, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0};
    tbl[5] = '{1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 8'hA5, 5'd1, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB1, 5'd2, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hC2, 5'd1, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC2, 5'd0, 1'b0};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC2, 5'd0, 1'b0};

    rtbl[0] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0};
    rtbl[1] = '{1'b1, 8'h77, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0};
    rtbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd1, 1'b0};
    rtbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 5'd1, 1'b0};
    rtbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h77, 5'd0, 1'b0};
    rtbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h77, 5'd0, 1'b0};

    // Reset state, then release with s_valid=1/0xA5 already asserted.
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst s_ready", 32'(s_ready), 0);
    check("rst m_valid", 32'(m_valid), 0);
    check("rst count", 32'(count), 0);
    check("rst m_data", 32'(m_data), 0);
    check("rst almost_full", 32'(almost_full), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      s_valid = tbl[i].sv; s_data = tbl[i].sd; m_ready = tbl[i].mr;
      check_vec($sformatf("t1 row%0d", i), tbl[i]);
    end
    @(negedge clk);

    // Fill with m_ready=0: 16 array words + 1 output word, then one rejected attempt.
    for (int j = 0; j <= 17; j++) begin
      int arr;
      arr = j - ((j >= 2) ? 1 : 0);
      check($sformatf("t2 j%0d count", j), 32'(count), 32'(j));
      check($sformatf("t2 j%0d m_valid", j), 32'(m_valid), 32'(j >= 2));
      check($sformatf("t2 j%0d almost_full", j), 32'(almost_full), 32'(arr >= 12));
      check($sformatf("t2 j%0d s_ready", j), 32'(s_ready), 32'(arr < 16));
      if (j >= 2) check($sformatf("t2 j%0d m_data", j), 32'(m_data), 0);
      s_valid = 1'b1;
      s_data  = (j < 17) ? 8'(j) : 8'hEE;
      @(negedge clk);
    end
    check("t2 overflow count", 32'(count), 17);
    check("t2 overflow s_ready", 32'(s_ready), 0);
    check("t2 overflow m_data", 32'(m_data), 0);

    // Drain from full with no writes.
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i <= 17; i++) begin
      if (i <= 16) begin
        check($sformatf("t3 i%0d m_valid", i), 32'(m_valid), 1);
        check($sformatf("t3 i%0d m_data", i), 32'(m_data), 32'(i));
        check($sformatf("t3 i%0d count", i), 32'(count), 32'(17 - i));
        check($sformatf("t3 i%0d s_ready", i), 32'(s_ready), 32'(i >= 1));
        check($sformatf("t3 i%0d almost_full", i), 32'(almost_full), 32'((16 - i) >= 12));
      end else begin
        check("t3 end m_valid", 32'(m_valid), 0);
        check("t3 end count", 32'(count), 0);
        check("t3 end m_data", 32'(m_data), 32'h10);
        check("t3 end s_ready", 32'(s_ready), 1);
      end
      @(negedge clk);
    end

    // Streaming 40 words at m_ready=1: one word per cycle, count steady at 2.
    for (int n = 0; n <= 42; n++) begin
      int ec;
      logic emv;
      ec  = (n == 0) ? 0 : (n == 1) ? 1 : (n <= 40) ? 2 : (n == 41) ? 1 : 0;
      emv = (n >= 2) && (n <= 41);
      check($sformatf("t4 n%0d count", n), 32'(count), 32'(ec));
      check($sformatf("t4 n%0d m_valid", n), 32'(m_valid), 32'(emv));
      check($sformatf("t4 n%0d s_ready", n), 32'(s_ready), 1);
      if (emv) begin
        exp_w = 8'(8'h80 + n - 2);
        check($sformatf("t4 n%0d m_data", n), 32'(m_data), 32'(exp_w));
      end
      s_valid = (n < 40); s_data = 8'(8'h80 + n); m_ready = 1'b1;
      @(negedge clk);
    end

    // Random backpressure with continuous s_valid, scoreboard ordering.
    nxt = 8'h40; hold = 1'b0; hold_d = 8'h00;
    for (int c = 0; c < 220; c++) begin
      if (hold) begin
        check($sformatf("t5 c%0d hold m_valid", c), 32'(m_valid), 1);
        check($sformatf("t5 c%0d hold m_data", c), 32'(m_data), 32'(hold_d));
      end
      check($sformatf("t5 c%0d count", c), 32'(count), 32'(q.size()));
      s_valid = 1'b1; s_data = nxt;
      m_ready = (c < 100) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          cmp++; fails++;
          $display("FAIL t5 c%0d extra word: got 0x%0h with nothing outstanding", c, m_data);
        end else begin
          exp_w = q.pop_front();
          check($sformatf("t5 c%0d order", c), 32'(m_data), 32'(exp_w));
        end
      end
      if (s_ready) begin
        q.push_back(nxt);
        nxt = nxt + 8'd1;
      end
      hold = m_valid && !m_ready; hold_d = m_data;
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      check($sformatf("t5 drain c%0d count", c), 32'(count), 32'(q.size()));
      m_ready = 1'b1;
      if (m_valid) begin
        exp_w = q.pop_front();
        check($sformatf("t5 drain c%0d order", c), 32'(m_data), 32'(exp_w));
      end
      @(negedge clk);
    end
    check("t5 words outstanding", 32'(q.size()), 0);
    check("t5 final count", 32'(count), 0);

    // Async reset with 5 words held, then clean restart.
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s_valid = 1'b1; s_data = 8'(8'h31 + k);
      @(negedge clk);
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("t6 pre count", 32'(count), 5);
    check("t6 pre m_data", 32'(m_data), 32'h31);
    #2 rst_n = 1'b0;
    #1;
    check("t6 async m_valid", 32'(m_valid), 0);
    check("t6 async count", 32'(count), 0);
    check("t6 async s_ready", 32'(s_ready), 0);
    check("t6 async m_data", 32'(m_data), 0);
    check("t6 async almost_full", 32'(almost_full), 0);
    repeat (2) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) rst_n = 1'b1;
      s_valid = rtbl[k].sv; s_data = rtbl[k].sd; m_ready = rtbl[k].mr;
      check_vec($sformatf("t6 row%0d", k), rtbl[k]);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

endmodule
